// File: rtl/config_reg_arbiter.sv
// ============================================================================
// Module   : config_reg_arbiter
// Purpose  : Two-requester write arbiter (A = SPI, B = sequencer) that owns
//            the output-enable / PWM-enable / duty-cycle register bank.
// Options  : CFG_ARB_ROUND_ROBIN_EN selects round-robin tie-break; when it
//            is undefined, A always wins simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_reg_arbiter #(
  parameter int NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       err_clr,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_done,
  output logic       err_addr,
  output logic [7:0] wr_count
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_COMMIT = 1'b1;
  localparam logic [6:0] NUM_REGS_A   = 7'(NUM_REGS);

  logic [0:0] state_q, state_d;
  logic       grant_a, grant_b;
  logic       accept_a, accept_b;
  logic       commit, addr_ok;

  logic [6:0] hold_addr_q, hold_addr_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       wr_done_q, wr_done_d;
  logic       err_addr_q, err_addr_d;
  logic [7:0] wr_count_q, wr_count_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

`ifdef CFG_ARB_ROUND_ROBIN_EN
  // Set when B holds the most recent grant, so A wins the next tie.
  logic last_b_q, last_b_d;
`endif

  // Arbitration: combinational from valids and pointer only, never from data.
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid && !a_valid;
`ifdef CFG_ARB_ROUND_ROBIN_EN
    if (a_valid && b_valid) begin
      grant_a = last_b_q;
      grant_b = !last_b_q;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE:   if (accept_a || accept_b) state_d = STATE_COMMIT;
      STATE_COMMIT: state_d = STATE_IDLE;
      default:      state_d = STATE_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    commit  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        a_ready = grant_a;
        b_ready = grant_b;
      end
      STATE_COMMIT: commit = 1'b1;
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
  end

  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;
  assign addr_ok  = hold_addr_q < NUM_REGS_A;

  always_comb begin
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (accept_a) begin
      hold_addr_d = a_addr;
      hold_data_d = a_data;
    end else if (accept_b) begin
      hold_addr_d = b_addr;
      hold_data_d = b_data;
    end
  end

  always_comb begin
    wr_done_d  = commit && addr_ok;
    wr_count_d = (commit && addr_ok) ? wr_count_q + 8'd1 : wr_count_q;
    err_addr_d = err_addr_q;
    // A dropped write in the same cycle as err_clr keeps the flag set.
    if (commit && !addr_ok) begin
      err_addr_d = 1'b1;
    end else if (err_clr) begin
      err_addr_d = 1'b0;
    end
  end

`ifdef CFG_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_b_d = last_b_q;
    if (accept_a) begin
      last_b_d = 1'b0;
    end else if (accept_b) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_q <= 7'd0;
      hold_data_q <= 8'd0;
      wr_done_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      wr_count_q  <= 8'd0;
    end else begin
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      wr_done_q   <= wr_done_d;
      err_addr_q  <= err_addr_d;
      wr_count_q  <= wr_count_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    always_comb begin
      regs_d[i] = regs_q[i];
      if (commit && (hold_addr_q == 7'(i))) begin
        regs_d[i] = hold_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[i] <= 8'h00;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_done         = wr_done_q;
  assign err_addr        = err_addr_q;
  assign wr_count        = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_config_reg_arbiter.sv
// ============================================================================
// Module   : tb_config_reg_arbiter
// Purpose  : Self-checking bench for config_reg_arbiter against a
//            transaction-level model (scheduled commits, grant policy).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, err_clr = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, wr_done, err_addr;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle, wr_count;

  int checks = 0;
  int errors = 0;

  config_reg_arbiter #(.NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .err_clr(err_clr),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .wr_done(wr_done), .err_addr(err_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: a write accepted in step k becomes visible in step k+2;
  // the arbiter cannot grant again until step k+2.
  typedef struct {
    int         due;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        pend[$];
  logic [7:0] m_regs [5];
  int         m_count, m_cyc, m_free;
  logic       m_err, m_last_b, m_clr_prev;
  logic       exp_wr_done, exp_a_ready, exp_b_ready;
  logic       obs_a_ready, obs_b_ready;

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
            en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic logic [6:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 7));
    return (r == 7) ? 7'h7F : 7'(r);
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_count = 0; m_free = 0; m_err = 1'b0; m_last_b = 1'b1;
    m_clr_prev = 1'b0; exp_wr_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance one cycle: update model, drive inputs, predict and sample readies.
  task automatic cycle(input logic av, input logic [6:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [6:0] ba, input logic [7:0] bd,
                       input logic clr);
    wr_t w;
    @(negedge clk);
    m_cyc++;
    exp_wr_done = 1'b0;
    if (m_clr_prev) m_err = 1'b0;
    while (pend.size() > 0 && pend[0].due == m_cyc) begin
      w = pend.pop_front();
      if (int'(w.addr) < 5) begin
        m_regs[int'(w.addr)] = w.data;
        m_count = (m_count + 1) % 256;
        exp_wr_done = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_clr_prev = clr;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    err_clr = clr;
    #1;
    exp_a_ready = 1'b0;
    exp_b_ready = 1'b0;
    if (m_cyc >= m_free) begin
      if (av && bv) begin
`ifdef CFG_ARB_ROUND_ROBIN_EN
        if (m_last_b) exp_a_ready = 1'b1;
        else          exp_b_ready = 1'b1;
`else
        exp_a_ready = 1'b1;
`endif
      end else if (av) begin
        exp_a_ready = 1'b1;
      end else if (bv) begin
        exp_b_ready = 1'b1;
      end
    end
    obs_a_ready = a_ready;
    obs_b_ready = b_ready;
    if (exp_a_ready) begin
      pend.push_back('{due: m_cyc + 2, addr: aa, data: ad});
      m_free = m_cyc + 2; m_last_b = 1'b0;
    end
    if (exp_b_ready) begin
      pend.push_back('{due: m_cyc + 2, addr: ba, data: bd});
      m_free = m_cyc + 2; m_last_b = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (dut_regs() !== 40'h0 || wr_count !== 8'h00 || err_addr !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial regs=%h cnt=%h err=%b done=%b required all zero",
               dut_regs(), wr_count, err_addr, wr_done);
    end
    cycle(1'b1, 7'h00, 8'h5A, 1'b0, 7'h0, 8'h0, 1'b0);
    cycle(1'b0, 7'h00, 8'h00, 1'b0, 7'h0, 8'h0, 1'b0);
    cycle(1'b0, 7'h00, 8'h00, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (en_reg_out_7_0 !== 8'h5A) begin
      errors++;
      $display("FAIL reset_prewrite got=%h required=5a", en_reg_out_7_0);
    end
    cycle(1'b1, 7'h04, 8'h80, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (obs_a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept a_ready=%b required=1", obs_a_ready);
    end
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0;
    #1;
    checks++;
    if (dut_regs() !== 40'h0 || wr_count !== 8'h00 || err_addr !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcommit regs=%h cnt=%h err=%b done=%b required all zero",
               dut_regs(), wr_count, err_addr, wr_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
      checks++;
      if (wr_done !== 1'b0 || pwm_duty_cycle !== 8'h00) begin
        errors++;
        $display("FAIL reset_after k=%0d done=%b pwm=%h required 0/00", k, wr_done, pwm_duty_cycle);
      end
    end
  endtask

  task automatic test_single_write();
    cycle(1'b1, 7'h04, 8'h80, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready a=%b b=%b required 1/0", obs_a_ready, obs_b_ready);
    end
    cycle(1'b0, 7'h00, 8'h00, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (obs_a_ready !== 1'b0 || wr_done !== 1'b0 || pwm_duty_cycle !== 8'h00) begin
      errors++;
      $display("FAIL single_commit a_ready=%b done=%b pwm=%h required 0/0/00",
               obs_a_ready, wr_done, pwm_duty_cycle);
    end
    cycle(1'b0, 7'h00, 8'h00, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (pwm_duty_cycle !== 8'h80 || wr_done !== 1'b1 || wr_count !== 8'(m_count) || m_count != 1) begin
      errors++;
      $display("FAIL single_result pwm=%h done=%b cnt=%h required 80/1/01",
               pwm_duty_cycle, wr_done, wr_count);
    end
    cycle(1'b0, 7'h00, 8'h00, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse done=%b required=0", wr_done);
    end
  endtask

  task automatic test_contention();
    logic [6:0] a_pat, b_pat, a_req, b_req;
    a_pat = '0; b_pat = '0;
`ifdef CFG_ARB_ROUND_ROBIN_EN
    a_req = 7'b0010001; b_req = 7'b1000100;
`else
    a_req = 7'b0010101; b_req = 7'b1000000;
`endif
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(k < 6, 7'h00, 8'hAA, 1'b1, 7'h02, 8'h55, 1'b0);
      a_pat[k] = obs_a_ready;
      b_pat[k] = obs_b_ready;
      checks++;
      if (obs_a_ready !== exp_a_ready || obs_b_ready !== exp_b_ready) begin
        errors++;
        $display("FAIL contention_grant k=%0d a=%b b=%b required %b/%b",
                 k, obs_a_ready, obs_b_ready, exp_a_ready, exp_b_ready);
      end
    end
    checks++;
    if (a_pat !== a_req || b_pat !== b_req) begin
      errors++;
      $display("FAIL contention_pattern a=%b b=%b required %b/%b", a_pat, b_pat, a_req, b_req);
    end
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (en_reg_out_7_0 !== 8'hAA || en_reg_pwm_7_0 !== 8'h55 || dut_regs() !== model_regs()) begin
      errors++;
      $display("FAIL contention_regs got=%h required=%h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_invalid_addr();
    cycle(1'b0, 7'h0, 8'h0, 1'b1, 7'h05, 8'hFF, 1'b0);
    checks++;
    if (obs_b_ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_accept b_ready=%b required=1", obs_b_ready);
    end
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (err_addr !== 1'b1 || wr_done !== 1'b0 || dut_regs() !== model_regs() || wr_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL invalid_drop err=%b done=%b regs=%h cnt=%h required 1/0/%h/%h",
               err_addr, wr_done, dut_regs(), wr_count, model_regs(), 8'(m_count));
    end
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b1);
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (err_addr !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear err=%b required=0", err_addr);
    end
    cycle(1'b0, 7'h0, 8'h0, 1'b1, 7'h7F, 8'h00, 1'b0);
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b1);
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    checks++;
    if (err_addr !== 1'b1 || m_err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_setwins err=%b required=1", err_addr);
    end
    cycle(1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int i;
    i = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(i < 5, 7'(i), 8'((i + 1) * 17), 1'b0, 7'h0, 8'h0, 1'b0);
      checks++;
      if (obs_a_ready !== exp_a_ready || (i < 5 && obs_a_ready !== ((k % 2) == 0))) begin
        errors++;
        $display("FAIL b2b_ready k=%0d got=%b required=%b", k, obs_a_ready, exp_a_ready);
      end
      if (exp_a_ready) i++;
    end
    checks++;
    if (dut_regs() !== 40'h5544332211 || wr_count !== 8'd5) begin
      errors++;
      $display("FAIL b2b_final regs=%h cnt=%h required 5544332211/05", dut_regs(), wr_count);
    end
  endtask

  task automatic test_random();
    logic av, bv, clr;
    logic [6:0] aa, ba;
    logic [7:0] ad, bd;
    av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!av) begin av = 1'($urandom_range(0, 1)); aa = rand_addr(); ad = 8'($urandom); end
      if (!bv) begin bv = 1'($urandom_range(0, 1)); ba = rand_addr(); bd = 8'($urandom); end
      clr = ($urandom_range(0, 7) == 0);
      cycle(av, aa, ad, bv, ba, bd, clr);
      checks++;
      if (obs_a_ready !== exp_a_ready || obs_b_ready !== exp_b_ready) begin
        errors++;
        $display("FAIL random_ready k=%0d a=%b b=%b required %b/%b",
                 k, obs_a_ready, obs_b_ready, exp_a_ready, exp_b_ready);
      end
      checks++;
      if (dut_regs() !== model_regs() || wr_done !== exp_wr_done ||
          err_addr !== m_err || wr_count !== 8'(m_count)) begin
        errors++;
        $display("FAIL random_state k=%0d regs=%h done=%b err=%b cnt=%h required %h/%b/%b/%h",
                 k, dut_regs(), wr_done, err_addr, wr_count,
                 model_regs(), exp_wr_done, m_err, 8'(m_count));
      end
      if (exp_a_ready || $urandom_range(0, 7) == 0) av = 1'b0;
      if (exp_b_ready || $urandom_range(0, 7) == 0) bv = 1'b0;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 514; k++) begin
      cycle(k < 512, 7'($urandom_range(0, 4)), 8'($urandom), 1'b0, 7'h0, 8'h0, 1'b0);
      if (k == 255) begin
        checks++;
        if (wr_count !== 8'(m_count)) begin
          errors++;
          $display("FAIL wrap_mid cnt=%h required=%h", wr_count, 8'(m_count));
        end
      end
    end
    checks++;
    if (wr_count !== 8'h00 || m_count != 0 || dut_regs() !== model_regs()) begin
      errors++;
      $display("FAIL wrap_final cnt=%h regs=%h required 00/%h", wr_count, dut_regs(), model_regs());
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_write();
    test_contention();
    test_invalid_addr();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
